// File: rtl/ledg_share_arbiter_if.sv
// ledg_share_arbiter_if: one Avalon-MM-style link used by the shared LED PIO arbiter.
// Each requester and the PIO side are separate instances of this interface.
//
// Signals
//   address     [1:0]  word address
//   chipselect         request valid, held until waitrequest is low
//   write_n            0 = write, 1 = read
//   writedata   [31:0] write data
//   readdata    [31:0] read data
//   waitrequest        stall back to the initiator (unused on the PIO link)
//
// Modports
//   master : the initiating side (drives address/chipselect/write_n/writedata)
//   slave  : the target side (drives readdata/waitrequest)
interface ledg_share_arbiter_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  // The PIO is combinational and never stalls, so the master view omits waitrequest.
  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata,
    output waitrequest
  );
endinterface

// File: rtl/ledg_share_arbiter.sv
// ledg_share_arbiter: two-requester round-robin arbiter in front of a single LED PIO slave.
//
// Each granted request runs IDLE -> XFER -> ACK. The request is latched at the grant, so a
// requester dropping chipselect after being granted cannot abort the transfer. The PIO is
// driven for exactly the XFER cycle; the owner sees waitrequest low during ACK.
//
// Ports
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   s0, s1   requester links (slave modport): address, chipselect, write_n, writedata in;
//            readdata, waitrequest out
//   m        PIO link (master modport): address, chipselect, write_n, writedata out;
//            readdata in (combinational from the PIO)
//
// Configuration
//   LEDG_ARB_LOCK_EN  when defined, address 3 is an arbiter-local lock register
//                     ({30'b0, lock_owner, lock_valid}); while the lock is held, writes to
//                     addresses 0-2 from the other requester are acknowledged but dropped.
//                     When undefined, every address is forwarded to the PIO.
module ledg_share_arbiter (
  input  logic                      clk,
  input  logic                      reset_n,
  ledg_share_arbiter_if.slave       s0,
  ledg_share_arbiter_if.slave       s1,
  ledg_share_arbiter_if.master      m
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StXfer = 2'd1;
  localparam logic [1:0] StAck  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_owner_q, last_owner_d;

  // Latched copy of the granted request.
  logic [1:0]  addr_q, addr_d;
  logic        write_n_q, write_n_d;
  logic [31:0] wdata_q, wdata_d;
  // Whether the latched request actually reaches the PIO.
  logic        fwd_q, fwd_d;

  // PIO address/data values held between forwarded transfers.
  logic [1:0]  hold_addr_q, hold_addr_d;
  logic [31:0] hold_wdata_q, hold_wdata_d;

  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  // Grant selection: a lone request wins; on a tie the requester that was not served last wins.
  logic        gnt1;
  logic        any_req;
  logic [1:0]  sel_addr;
  logic        sel_write_n;
  logic [31:0] sel_wdata;
  logic        grant_fwd;
  logic [31:0] xfer_rdata;
  logic        m_active;

  assign any_req     = s0.chipselect | s1.chipselect;
  assign gnt1        = s1.chipselect & (~s0.chipselect | ~last_owner_q);
  assign sel_addr    = gnt1 ? s1.address   : s0.address;
  assign sel_write_n = gnt1 ? s1.write_n   : s0.write_n;
  assign sel_wdata   = gnt1 ? s1.writedata : s0.writedata;

`ifdef LEDG_ARB_LOCK_EN
  logic lock_valid_q, lock_valid_d;
  logic lock_owner_q, lock_owner_d;
  logic sel_lock_hit;
  logic sel_drop;

  // Lock accesses stay local; writes from the non-holder are swallowed while the lock is held.
  assign sel_lock_hit = (sel_addr == 2'd3);
  assign sel_drop     = lock_valid_q & (lock_owner_q != gnt1) & ~sel_write_n & ~sel_lock_hit;
  assign grant_fwd    = ~sel_lock_hit & ~sel_drop;
  assign xfer_rdata   = (addr_q == 2'd3) ? {30'b0, lock_owner_q, lock_valid_q} : m.readdata;
`else
  assign grant_fwd    = 1'b1;
  assign xfer_rdata   = m.readdata;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    addr_d       = addr_q;
    write_n_d    = write_n_q;
    wdata_d      = wdata_q;
    fwd_d        = fwd_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
`ifdef LEDG_ARB_LOCK_EN
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
`endif

    case (state_q)
      StIdle: begin
        if (any_req) begin
          owner_d   = gnt1;
          addr_d    = sel_addr;
          write_n_d = sel_write_n;
          wdata_d   = sel_wdata;
          fwd_d     = grant_fwd;
          state_d   = StXfer;
        end
      end
      StXfer: begin
        if (fwd_q) begin
          hold_addr_d  = addr_q;
          hold_wdata_d = wdata_q;
        end
        if (write_n_q) begin
          if (owner_q) rdata1_d = xfer_rdata;
          else         rdata0_d = xfer_rdata;
        end
`ifdef LEDG_ARB_LOCK_EN
        if (addr_q == 2'd3 && !write_n_q) begin
          if (wdata_q[0]) begin
            if (!lock_valid_q || lock_owner_q == owner_q) begin
              lock_valid_d = 1'b1;
              lock_owner_d = owner_q;
            end
          end else if (lock_valid_q && lock_owner_q == owner_q) begin
            lock_valid_d = 1'b0;
          end
        end
`endif
        state_d = StAck;
      end
      StAck: begin
        last_owner_d = owner_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      addr_q       <= 2'd0;
      write_n_q    <= 1'b1;
      wdata_q      <= 32'd0;
      fwd_q        <= 1'b0;
      hold_addr_q  <= 2'd0;
      hold_wdata_q <= 32'd0;
      rdata0_q     <= 32'd0;
      rdata1_q     <= 32'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      write_n_q    <= write_n_d;
      wdata_q      <= wdata_d;
      fwd_q        <= fwd_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

`ifdef LEDG_ARB_LOCK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_valid_q <= 1'b0;
      lock_owner_q <= 1'b0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
    end
  end
`endif

  // PIO side: only a forwarded XFER touches the bus; otherwise address/data hold.
  assign m_active     = (state_q == StXfer) & fwd_q;
  assign m.chipselect = m_active;
  assign m.write_n    = m_active ? write_n_q : 1'b1;
  assign m.address    = m_active ? addr_q    : hold_addr_q;
  assign m.writedata  = m_active ? wdata_q   : hold_wdata_q;

  // Requester side.
  assign s0.waitrequest = s0.chipselect & ~((state_q == StAck) & ~owner_q);
  assign s1.waitrequest = s1.chipselect & ~((state_q == StAck) &  owner_q);
  assign s0.readdata    = rdata0_q;
  assign s1.readdata    = rdata1_q;

endmodule
